// File: rtl/alu_instr_sequencer_if.sv
// Instruction/start handshake, status and debug-read bundle
// between the instruction source and alu_instr_sequencer.
interface alu_instr_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              s;
  logic [15:0]       in;
  logic              w;
  logic              done;
  logic              err;
  logic [2:0]        status;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  s, in, dbg_addr,
    output w, done, err, status, dbg_data
  );

  modport master (
    output s, in, dbg_addr,
    input  w, done, err, status, dbg_data
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle decode/control unit with 8-entry register file,
// {V,N,Z} status and a 16-bit ADD/SUB/AND/NOT-B ALU.
module alu_instr_sequencer #(
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  alu_instr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WRIMM,
    GETA,
    GETB,
    EXEC,
    WRITE
  } state_t;

  localparam int MSB = DATA_W - 1;

  state_t state, nxt;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, c;
  logic [DATA_W-1:0] rf [8];
  logic [2:0]        status;
  logic              done, err;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic [7:0] imm8;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign imm8   = ir[7:0];

  logic is_movi, is_movr, is_alu, is_cmp;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);

  logic [DATA_W-1:0] src_m, shifted, sext;

  assign src_m = rf[rm];
  assign sext  = {{(DATA_W-8){imm8[7]}}, imm8};

  always_comb begin
    shifted = src_m;
    unique case (sh)
      2'b00: shifted = src_m;
      2'b01: shifted = {src_m[MSB-1:0], 1'b0};
      2'b10: shifted = {1'b0, src_m[MSB:1]};
      2'b11: shifted = {src_m[MSB], src_m[MSB:1]};
    endcase
  end

  logic [DATA_W-1:0] sum, diff, alu_out;
  logic              alu_v;

  assign sum  = a + b;
  assign diff = a - b;

  // MOV reg shares op=00 with ADD, so the ALU passes B unless the
  // opcode is an arithmetic/logic one.
  always_comb begin
    alu_out = b;
    alu_v   = 1'b0;
    if (is_alu) begin
      unique case (op)
        2'b00: begin
          alu_out = sum;
          alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        end
        2'b01: begin
          alu_out = diff;
          alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        end
        2'b10: alu_out = a & b;
        2'b11: alu_out = ~b;
      endcase
    end
  end

  logic load_ir, load_a, load_b, load_c, load_st;
  logic wr_rd, wr_imm, fin, bad;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    load_ir = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_c  = 1'b0;
    load_st = 1'b0;
    wr_rd   = 1'b0;
    wr_imm  = 1'b0;
    fin     = 1'b0;
    bad     = 1'b0;
    unique case (state)
      WAIT: begin
        if (bus.s) begin
          load_ir = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_movi: nxt = WRIMM;
          is_movr: nxt = GETB;
          is_alu:  nxt = GETA;
          default: begin
            nxt = WAIT;
            fin = 1'b1;
            bad = 1'b1;
          end
        endcase
      end
      GETA: begin
        load_a = 1'b1;
        nxt    = GETB;
      end
      GETB: begin
        load_b = 1'b1;
        nxt    = EXEC;
      end
      EXEC: begin
        load_c  = 1'b1;
        load_st = is_alu;
        if (is_cmp) begin
          nxt = WAIT;
          fin = 1'b1;
        end else begin
          nxt = WRITE;
        end
      end
      WRITE: begin
        wr_rd = 1'b1;
        nxt   = WAIT;
        fin   = 1'b1;
      end
      WRIMM: begin
        wr_imm = 1'b1;
        nxt    = WAIT;
        fin    = 1'b1;
      end
      default: nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      c      <= '0;
      status <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      done <= fin;
      err  <= bad;
      if (load_ir) ir <= bus.in;
      if (load_a)  a  <= rf[rn];
      if (load_b)  b  <= shifted;
      if (load_c)  c  <= alu_out;
      if (load_st)
        status <= {alu_v, alu_out[MSB], alu_out == '0};
      if (wr_rd)  rf[rd] <= c;
      if (wr_imm) rf[rn] <= sext;
    end
  end

  assign bus.w        = (state == WAIT);
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.status   = status;
  assign bus.dbg_data = rf[bus.dbg_addr];

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Vector-table and scoreboard bench for alu_instr_sequencer.
// Includes reset-state, busy-s and reset-during-EXEC sequences.
module tb_alu_instr_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_instr_sequencer_if #(.DATA_W(16)) bus ();

  alu_instr_sequencer #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    int          lat;
    bit          err;
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] val;
    logic [2:0]  st;
  } vec_t;

  vec_t        vecs [16];
  vec_t        sb [$];
  logic [15:0] model [8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = i[2:0];
      #1;
      chk($sformatf("%s R%0d", tag, i), {16'h0, bus.dbg_data},
          {16'h0, model[i]});
    end
  endtask

  // Drive one instruction, measure latency in clocks from the
  // s-sampling edge, and flag any cycle where w was high while busy.
  task automatic issue(input logic [15:0] instr,
                       output int lat, output bit busy_w);
    @(negedge clk);
    bus.in = instr;
    bus.s  = 1'b1;
    @(posedge clk);
    #1;
    bus.s  = 1'b0;
    lat    = 0;
    busy_w = bus.w;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.w) busy_w = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   lat;
    bit   busy_w;
    vec_t e;
    sb.push_back(v);
    issue(v.instr, lat, busy_w);
    e = sb.pop_front();
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " done"}, {31'h0, bus.done}, 32'h1);
    chk({tag, " err"}, {31'h0, bus.err}, {31'h0, e.err});
    chk({tag, " status"}, {29'h0, bus.status}, {29'h0, e.st});
    chk({tag, " busy_w"}, {31'h0, busy_w}, 32'h0);
    if (e.wr) model[e.addr] = e.val;
    chk_regs(tag);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, {31'h0, bus.done}, 32'h0);
    chk({tag, " w_idle"}, {31'h0, bus.w}, 32'h1);
  endtask

  initial begin
    int lat;
    bit busy_w;

    vecs[0]  = '{16'hD001, 2, 1'b0, 1'b1, 3'd0, 16'h0001, 3'b000};
    vecs[1]  = '{16'hD1FF, 2, 1'b0, 1'b1, 3'd1, 16'hFFFF, 3'b000};
    vecs[2]  = '{16'hA140, 5, 1'b0, 1'b1, 3'd2, 16'h0000, 3'b001};
    vecs[3]  = '{16'hD37F, 2, 1'b0, 1'b1, 3'd3, 16'h007F, 3'b001};
    vecs[4]  = '{16'hC091, 4, 1'b0, 1'b1, 3'd4, 16'h7FFF, 3'b001};
    vecs[5]  = '{16'hA4C0, 5, 1'b0, 1'b1, 3'd6, 16'h8000, 3'b110};
    vecs[6]  = '{16'hA921, 4, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b001};
    vecs[7]  = '{16'hC006, 4, 1'b0, 1'b1, 3'd0, 16'h8000, 3'b001};
    vecs[8]  = '{16'hB8B8, 5, 1'b0, 1'b1, 3'd5, 16'h3FFF, 3'b000};
    vecs[9]  = '{16'hA121, 5, 1'b0, 1'b1, 3'd1, 16'hFFFE, 3'b010};
    vecs[10] = '{16'hC0E9, 4, 1'b0, 1'b1, 3'd7, 16'hFFFC, 3'b010};
    vecs[11] = '{16'hE000, 1, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b010};
    vecs[12] = '{16'hA804, 4, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b100};
    vecs[13] = '{16'hB441, 5, 1'b0, 1'b1, 3'd2, 16'h7FFE, 3'b000};
    vecs[14] = '{16'hC800, 1, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b000};
    vecs[15] = '{16'hD480, 2, 1'b0, 1'b1, 3'd4, 16'hFF80, 3'b000};

    for (int i = 0; i < 8; i++) model[i] = 16'h0;

    bus.s        = 1'b0;
    bus.in       = 16'h0;
    bus.dbg_addr = 3'd0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset w", {31'h0, bus.w}, 32'h1);
    chk("reset done", {31'h0, bus.done}, 32'h0);
    chk("reset err", {31'h0, bus.err}, 32'h0);
    chk("reset status", {29'h0, bus.status}, 32'h0);
    chk_regs("reset");

    for (int i = 0; i < 16; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // s and a new word during a busy MOV R3,R1 must be ignored
    @(negedge clk);
    bus.in = 16'hC061;
    bus.s  = 1'b1;
    @(posedge clk);
    #1;
    bus.in = 16'hD3AA;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.s  = 1'b0;
    lat    = 2;
    while (lat < 20 && !bus.done) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_s latency", lat, 4);
    chk("busy_s err", {31'h0, bus.err}, 32'h0);
    model[3] = 16'hFFFE;
    chk_regs("busy_s");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("busy_s no_restart", {31'h0, bus.w}, 32'h1);
      chk("busy_s no_done", {31'h0, bus.done}, 32'h0);
    end

    // Reset while an ADD sits in EXEC: no writeback, all state cleared
    @(negedge clk);
    bus.in = 16'hA140;
    bus.s  = 1'b1;
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exec w_busy", {31'h0, bus.w}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    chk("rst_exec w", {31'h0, bus.w}, 32'h1);
    chk("rst_exec done", {31'h0, bus.done}, 32'h0);
    chk("rst_exec status", {29'h0, bus.status}, 32'h0);
    chk_regs("rst_exec");
    repeat (6) @(posedge clk);
    #1;
    chk("rst_exec late_done", {31'h0, bus.done}, 32'h0);
    chk_regs("rst_exec_late");

    run_vec(vecs[0], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
